uart_core_param: RTL and testbench

//  Parametrised full-duplex UART core; successor to the fixed 8N1 TX/RX pair.

---
 rtl/uart_core_param.sv | 172 +++++++++++++++++
 tb/tb_uart_core_param.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_core_param.sv
// uart_core_param: parametrised full-duplex UART with parity, 1/2 stop bits, error flags and loopback
module uart_core_param #(
  parameter int CLK_FREQ   = 1000000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       newd,
  input  logic [7:0] dintx,
  input  logic       loopback,
  input  logic       rx,
  output logic       tx,
  output logic       busy,
  output logic       donetx,
  output logic [7:0] doutrx,
  output logic       donerx,
  output logic       perr,
  output logic       ferr
);
  localparam int CPB = CLK_FREQ / BAUD_RATE;
  localparam int CW = $clog2(CPB);
  localparam logic [CW-1:0] LAST = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF = CW'(CPB / 2 - 1);
  localparam logic [2:0] DLAST = 3'(DATA_BITS - 1);
  localparam logic [2:0] SLAST = 3'(STOP_BITS - 1);
  localparam logic ODD = PARITY_ODD != 0;
  localparam logic PEN = PARITY_EN != 0;
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, WAITHI} state_t;
  state_t ts, ts_n, rs, rs_n;
  logic [CW-1:0] tc, tc_n, rc, rc_n;
  logic [2:0] ti, ti_n, ri, ri_n;
  logic [DATA_BITS-1:0] td, td_n, rd, rd_n;
  logic donetx_n, tx_i, tend, s1, s2, rp, rl, rend;
  logic rpe, rpe_n, rfe, rfe_n, donerx_n, perr_n, ferr_n;
  logic [7:0] doutrx_n;
  assign tend = tc == LAST;
  assign tx_i = (ts == START) ? 1'b0 : (ts == DATA) ? td[ti] : (ts == PAR) ? (^td ^ ODD) : 1'b1;
  assign tx = loopback | tx_i;
  assign busy = ts != IDLE;
  always_comb begin
    ts_n = ts;
    tc_n = tend ? '0 : tc + CW'(1);
    ti_n = ti;
    td_n = td;
    donetx_n = 1'b0;
    case (ts)
      IDLE: begin
        tc_n = '0;
        if (newd) begin
          ts_n = START;
          td_n = dintx[DATA_BITS-1:0];
          ti_n = '0;
        end
      end
      START: ts_n = tend ? DATA : ts;
      DATA: if (tend) begin
        ti_n = (ti == DLAST) ? 3'd0 : ti + 3'd1;
        ts_n = (ti != DLAST) ? DATA : PEN ? PAR : STOP;
      end
      PAR: ts_n = tend ? STOP : ts;
      STOP: if (tend) begin
        ti_n = (ti == SLAST) ? 3'd0 : ti + 3'd1;
        ts_n = (ti == SLAST) ? IDLE : STOP;
        donetx_n = ti == SLAST;
      end
      default: ts_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ts <= IDLE;
      tc <= '0;
      ti <= '0;
      td <= '0;
      donetx <= 1'b0;
    end else begin
      ts <= ts_n;
      tc <= tc_n;
      ti <= ti_n;
      td <= td_n;
      donetx <= donetx_n;
    end
  end
  // internal loopback bypasses the synchroniser: tx_i is already in the clk domain
  assign rl = loopback ? tx_i : s2;
  assign rend = rc == LAST;
  always_comb begin
    rs_n = rs;
    rc_n = rc + CW'(1);
    ri_n = ri;
    rd_n = rd;
    rpe_n = rpe;
    rfe_n = rfe;
    donerx_n = 1'b0;
    doutrx_n = doutrx;
    perr_n = perr;
    ferr_n = ferr;
    case (rs)
      IDLE: begin
        rc_n = '0;
        rs_n = (rp & ~rl) ? START : IDLE;
      end
      START: if (rc == HALF) begin
        rc_n = '0;
        rs_n = rl ? IDLE : DATA;
        ri_n = '0;
        rpe_n = 1'b0;
        rfe_n = 1'b0;
      end
      DATA: if (rend) begin
        rc_n = '0;
        rd_n = {rl, rd[DATA_BITS-1:1]};
        ri_n = (ri == DLAST) ? 3'd0 : ri + 3'd1;
        rs_n = (ri != DLAST) ? DATA : PEN ? PAR : STOP;
      end
      PAR: if (rend) begin
        rc_n = '0;
        rpe_n = rl != (^rd ^ ODD);
        rs_n = STOP;
      end
      STOP: if (rend) begin
        rc_n = '0;
        ri_n = ri + 3'd1;
        rfe_n = rfe | ~rl;
        if (ri == SLAST) begin
          rs_n = (rfe | ~rl) ? WAITHI : IDLE;
          donerx_n = 1'b1;
          doutrx_n = 8'(rd);
          perr_n = PEN & rpe;
          ferr_n = rfe | ~rl;
        end
      end
      WAITHI: rs_n = rl ? IDLE : WAITHI;
      default: rs_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      rp <= 1'b1;
      rs <= IDLE;
      rc <= '0;
      ri <= '0;
      rd <= '0;
      rpe <= 1'b0;
      rfe <= 1'b0;
      donerx <= 1'b0;
      doutrx <= '0;
      perr <= 1'b0;
      ferr <= 1'b0;
    end else begin
      s1 <= rx;
      s2 <= s1;
      rp <= rl;
      rs <= rs_n;
      rc <= rc_n;
      ri <= ri_n;
      rd <= rd_n;
      rpe <= rpe_n;
      rfe <= rfe_n;
      donerx <= donerx_n;
      doutrx <= doutrx_n;
      perr <= perr_n;
      ferr <= ferr_n;
    end
  end
endmodule

// File: tb/tb_uart_core_param.sv
// tb_uart_core_param: scoreboard bench over 8N1, 8E1, 8N2 and 5N1 instances at 10 clocks per bit
module tb_uart_core_param;
  logic clk = 0, rst = 0, newd = 0, loopback = 0, rx = 1;
  logic [7:0] dintx = 0;
  logic [3:0] tx_o, busy_o, donetx_o, donerx_o, perr_o, ferr_o;
  logic [7:0] dout_o [4];
  int nvec = 0, nfail = 0, sel = 0, dtx_cnt = 0;
  logic [9:0] exp_q[$], got_q[$];
  always #5 clk = ~clk;
  uart_core_param #(.CLK_FREQ(1000000), .BAUD_RATE(100000)) u8n1 (.clk(clk), .rst(rst), .newd(newd),
    .dintx(dintx), .loopback(loopback), .rx(rx), .tx(tx_o[0]), .busy(busy_o[0]), .donetx(donetx_o[0]),
    .doutrx(dout_o[0]), .donerx(donerx_o[0]), .perr(perr_o[0]), .ferr(ferr_o[0]));
  uart_core_param #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .PARITY_EN(1)) u8e1 (.clk(clk), .rst(rst),
    .newd(newd), .dintx(dintx), .loopback(loopback), .rx(rx), .tx(tx_o[1]), .busy(busy_o[1]),
    .donetx(donetx_o[1]), .doutrx(dout_o[1]), .donerx(donerx_o[1]), .perr(perr_o[1]), .ferr(ferr_o[1]));
  uart_core_param #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .STOP_BITS(2)) u8n2 (.clk(clk), .rst(rst),
    .newd(newd), .dintx(dintx), .loopback(loopback), .rx(rx), .tx(tx_o[2]), .busy(busy_o[2]),
    .donetx(donetx_o[2]), .doutrx(dout_o[2]), .donerx(donerx_o[2]), .perr(perr_o[2]), .ferr(ferr_o[2]));
  uart_core_param #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(5)) u5n1 (.clk(clk), .rst(rst),
    .newd(newd), .dintx(dintx), .loopback(loopback), .rx(rx), .tx(tx_o[3]), .busy(busy_o[3]),
    .donetx(donetx_o[3]), .doutrx(dout_o[3]), .donerx(donerx_o[3]), .perr(perr_o[3]), .ferr(ferr_o[3]));
  always @(negedge clk) begin
    if (donerx_o[sel]) got_q.push_back({dout_o[sel], perr_o[sel], ferr_o[sel]});
    if (donetx_o[sel]) dtx_cnt++;
  end
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic start_tx(input logic [7:0] d);
    newd = 1;
    dintx = d;
    cyc(1);
    newd = 0;
  endtask
  task automatic send_rx(input logic [7:0] d, input int nb, input int pe, input logic pv,
                         input logic [1:0] st, input int ns);
    rx = 0;
    cyc(10);
    for (int i = 0; i < nb; i++) begin
      rx = d[i];
      cyc(10);
    end
    if (pe != 0) begin
      rx = pv;
      cyc(10);
    end
    for (int i = 0; i < ns; i++) begin
      rx = st[i];
      cyc(10);
    end
  endtask
  task automatic clear_sb(input int s);
    sel = s;
    exp_q.delete();
    got_q.delete();
    dtx_cnt = 0;
  endtask
  task automatic test_reset;
    logic [13:0] obs;
    cyc(3);
    for (int i = 0; i < 4; i++) begin
      obs = {tx_o[i], busy_o[i], donetx_o[i], donerx_o[i], perr_o[i], ferr_o[i], dout_o[i]};
      nvec++;
      if (obs !== {1'b1, 13'h0}) begin
        nfail++;
        $display("FAIL reset_state inst%0d: got %h want %h", i, obs, {1'b1, 13'h0});
      end
    end
    rst = 1;
    cyc(2);
  endtask
  task automatic test_loopback;
    int bc = 0, kd = 0;
    logic txhi = 1;
    logic [9:0] e, g;
    loopback = 1;
    cyc(2);
    clear_sb(0);
    exp_q.push_back({8'h55, 1'b0, 1'b0});
    start_tx(8'h55);
    for (int k = 1; k <= 200; k++) begin
      if (busy_o[0]) bc++;
      if (donetx_o[0] && kd == 0) kd = k;
      if (tx_o[0] !== 1'b1) txhi = 0;
      cyc(1);
    end
    nvec++; if (bc !== 100) begin nfail++; $display("FAIL lb_busy_len: got %0d want 100", bc); end
    nvec++; if (kd !== 101) begin nfail++; $display("FAIL lb_donetx_cycle: got %0d want 101", kd); end
    nvec++; if (dtx_cnt !== 1) begin nfail++; $display("FAIL lb_donetx_count: got %0d want 1", dtx_cnt); end
    nvec++; if (txhi !== 1'b1) begin nfail++; $display("FAIL lb_pin_idle: got %b want 1", txhi); end
    nvec++;
    if (got_q.size() !== exp_q.size()) begin
      nfail++;
      $display("FAIL lb_rx_count: got %0d want %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      nvec++; if (g !== e) begin nfail++; $display("FAIL lb_rx_data: got %h want %h", g, e); end
    end
    loopback = 0;
    cyc(5);
  endtask
  task automatic test_glitch;
    clear_sb(0);
    rx = 0;
    cyc(3);
    rx = 1;
    cyc(40);
    nvec++; if (got_q.size() !== 0) begin nfail++; $display("FAIL glitch_donerx: got %0d want 0", got_q.size()); end
    nvec++; if (dout_o[0] !== 8'h55) begin nfail++; $display("FAIL glitch_dout: got %h want 55", dout_o[0]); end
  endtask
  task automatic test_parity;
    int bc = 0;
    logic [10:0] cap = '1, want;
    logic [7:0] d = 8'h07;
    logic [9:0] e, g;
    clear_sb(1);
    want = {1'b1, ^d, d, 1'b0};
    start_tx(d);
    for (int k = 1; k <= 130; k++) begin
      if (busy_o[1]) bc++;
      if (k % 10 == 5 && k / 10 < 11) cap[k/10] = tx_o[1];
      cyc(1);
    end
    nvec++; if (bc !== 110) begin nfail++; $display("FAIL par_busy_len: got %0d want 110", bc); end
    nvec++; if (cap[9] !== 1'b1) begin nfail++; $display("FAIL par_tx_bit: got %b want 1", cap[9]); end
    nvec++; if (cap !== want) begin nfail++; $display("FAIL par_tx_frame: got %b want %b", cap, want); end
    exp_q.push_back({8'h07, 1'b1, 1'b0});
    send_rx(8'h07, 8, 1, 1'b0, 2'b11, 1);
    rx = 1;
    cyc(30);
    nvec++;
    if (got_q.size() !== exp_q.size()) begin
      nfail++;
      $display("FAIL par_rx_count: got %0d want %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      nvec++; if (g !== e) begin nfail++; $display("FAIL par_rx_data: got %h want %h", g, e); end
    end
  endtask
  task automatic test_break;
    logic [9:0] e, g;
    clear_sb(2);
    exp_q.push_back({8'hA3, 1'b0, 1'b1});
    send_rx(8'hA3, 8, 0, 1'b0, 2'b01, 2);
    rx = 0;
    cyc(50);
    nvec++; if (got_q.size() !== 1) begin nfail++; $display("FAIL brk_single: got %0d want 1", got_q.size()); end
    rx = 1;
    cyc(30);
    exp_q.push_back({8'h3C, 1'b0, 1'b0});
    send_rx(8'h3C, 8, 0, 1'b0, 2'b11, 2);
    rx = 1;
    cyc(30);
    nvec++;
    if (got_q.size() !== exp_q.size()) begin
      nfail++;
      $display("FAIL brk_rx_count: got %0d want %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      nvec++; if (g !== e) begin nfail++; $display("FAIL brk_rx_data: got %h want %h", g, e); end
    end
  endtask
  task automatic test_data5;
    int bc = 0;
    logic [9:0] e, g;
    loopback = 1;
    cyc(2);
    clear_sb(3);
    exp_q.push_back({8'h1F, 1'b0, 1'b0});
    start_tx(8'hFF);
    for (int k = 1; k <= 200; k++) begin
      newd = (k == 30);
      if (busy_o[3]) bc++;
      cyc(1);
    end
    newd = 0;
    nvec++; if (bc !== 70) begin nfail++; $display("FAIL d5_busy_len: got %0d want 70", bc); end
    nvec++; if (dtx_cnt !== 1) begin nfail++; $display("FAIL d5_donetx_count: got %0d want 1", dtx_cnt); end
    nvec++;
    if (got_q.size() !== exp_q.size()) begin
      nfail++;
      $display("FAIL d5_rx_count: got %0d want %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      nvec++; if (g !== e) begin nfail++; $display("FAIL d5_rx_data: got %h want %h", g, e); end
    end
    loopback = 0;
    cyc(5);
  endtask
  task automatic test_reset_mid;
    int bc = 0;
    logic [9:0] cap = '1, want;
    clear_sb(0);
    start_tx(8'h55);
    cyc(44);
    rst = 0;
    dtx_cnt = 0;
    #1;
    nvec++; if (tx_o[0] !== 1'b1) begin nfail++; $display("FAIL rm_tx_async: got %b want 1", tx_o[0]); end
    nvec++; if (busy_o[0] !== 1'b0) begin nfail++; $display("FAIL rm_busy_async: got %b want 0", busy_o[0]); end
    cyc(3);
    nvec++; if (dout_o[0] !== 8'h00) begin nfail++; $display("FAIL rm_dout_clr: got %h want 00", dout_o[0]); end
    rst = 1;
    cyc(150);
    nvec++; if (dtx_cnt !== 0) begin nfail++; $display("FAIL rm_no_donetx: got %0d want 0", dtx_cnt); end
    want = {1'b1, 8'h81, 1'b0};
    start_tx(8'h81);
    for (int k = 1; k <= 120; k++) begin
      if (busy_o[0]) bc++;
      if (k % 10 == 5 && k / 10 < 10) cap[k/10] = tx_o[0];
      cyc(1);
    end
    nvec++; if (cap !== want) begin nfail++; $display("FAIL rm_frame: got %b want %b", cap, want); end
    nvec++; if (bc !== 100) begin nfail++; $display("FAIL rm_busy_len: got %0d want 100", bc); end
    nvec++; if (dtx_cnt !== 1) begin nfail++; $display("FAIL rm_donetx_count: got %0d want 1", dtx_cnt); end
  endtask
  initial begin
    test_reset;
    test_loopback;
    test_glitch;
    test_parity;
    test_break;
    test_data5;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
